// File: rtl/shift_inverse_seq.sv
// shift_inverse_seq: recovers operand A from a shifter result Y, op code F and shift amount.
// Define SHIFT_INV_FAST_EN to replace the one-bit-per-clock SHIFT state with a single-cycle barrel inverse.
module shift_inverse_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y_in,
  input  logic [2:0]       f_in,
  input  logic [AMT_W-1:0] amt_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             exact_out,
  output logic             err_out
);

  typedef enum logic [1:0] {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL} mode_e;
`ifdef SHIFT_INV_FAST_EN
  typedef enum logic [1:0] {IDLE, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`endif

  localparam logic [WIDTH-1:0] ONES = '1;

  state_e           state_q;
  logic             inReady_q;
  logic             outValid_q;
  logic [WIDTH-1:0] work_q;
  logic             exact_q;
  logic             err_q;
`ifndef SHIFT_INV_FAST_EN
  mode_e            mode_q;
  logic [AMT_W-1:0] cnt_q;
`endif

  mode_e            mode_d;
  logic [AMT_W-1:0] n_d;
  logic [WIDTH-1:0] seed_d;
  logic             exact_d;
  logic             err_d;
  logic [WIDTH-1:0] lowMask;
  logic [WIDTH-1:0] topMask;
  logic [WIDTH-1:0] signMask;
  logic [AMT_W:0]   amtPlus1;

  // Rotates go through a doubled word so every amount, including zero, wraps cleanly.
  function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] v, input mode_e m,
                                                input logic [AMT_W-1:0] k);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v};
    case (m)
      MODE_SHR: return v >> k;
      MODE_SHL: return v << k;
      MODE_ROR: begin
        dbl = dbl >> k;
        return dbl[WIDTH-1:0];
      end
      default: begin
        dbl = dbl << k;
        return dbl[2*WIDTH-1:WIDTH];
      end
    endcase
  endfunction

  always_comb begin
    amtPlus1 = (AMT_W+1)'(amt_in) + (AMT_W+1)'(1);
    lowMask  = ~(ONES << amt_in);
    topMask  = ~(ONES >> amt_in);
    signMask = ~(ONES >> amtPlus1);
    mode_d   = MODE_SHR;
    n_d      = amt_in;
    seed_d   = y_in;
    exact_d  = 1'b0;
    err_d    = 1'b0;
    case (f_in)
      3'b000: begin
        n_d     = '0;
        exact_d = 1'b1;
      end
      3'b001: begin
        mode_d  = MODE_SHR;
        exact_d = (amt_in == '0);
        err_d   = |(y_in & lowMask);
      end
      3'b010: begin
        mode_d  = MODE_SHL;
        exact_d = (amt_in == '0);
        err_d   = |(y_in & topMask);
      end
      3'b011: begin
        mode_d  = MODE_SHL;
        exact_d = (amt_in == '0);
        err_d   = ((y_in & signMask) != '0) && ((y_in & signMask) != signMask);
      end
      3'b100: begin
        mode_d  = MODE_ROR;
        exact_d = 1'b1;
      end
      3'b101: begin
        mode_d  = MODE_ROL;
        exact_d = 1'b1;
      end
      3'b110: begin
        mode_d = MODE_SHR;
        n_d    = AMT_W'(1);
        err_d  = y_in[0];
      end
      default: begin
        n_d    = '0;
        seed_d = '0;
        err_d  = |y_in;
      end
    endcase
    if (err_d) exact_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      work_q     <= '0;
      exact_q    <= 1'b0;
      err_q      <= 1'b0;
`ifndef SHIFT_INV_FAST_EN
      mode_q     <= MODE_SHR;
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready comes up one edge after reset release before any request is taken
          if (!inReady_q) begin
            inReady_q <= 1'b1;
          end else if (in_valid) begin
            inReady_q <= 1'b0;
            exact_q   <= exact_d;
            err_q     <= err_d;
`ifdef SHIFT_INV_FAST_EN
            work_q     <= shiftBy(seed_d, mode_d, n_d);
            outValid_q <= 1'b1;
            state_q    <= DONE;
`else
            work_q <= seed_d;
            mode_q <= mode_d;
            cnt_q  <= n_d;
            if (n_d == '0) begin
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= SHIFT;
            end
`endif
          end
        end
`ifndef SHIFT_INV_FAST_EN
        SHIFT: begin
          work_q <= shiftBy(work_q, mode_q, AMT_W'(1));
          cnt_q  <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign a_out     = work_q;
  assign exact_out = exact_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_shift_inverse_seq.sv
// tb_shift_inverse_seq: directed checks of the shift inverse, iterative or SHIFT_INV_FAST_EN build.
module tb_shift_inverse_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y_in;
  logic [2:0] f_in;
  logic [1:0] amt_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] a_out;
  logic       exact_out;
  logic       err_out;

  int tests = 0;
  int fails = 0;
  int lat;

  shift_inverse_seq #(.WIDTH(4), .AMT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .f_in(f_in), .amt_in(amt_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .exact_out(exact_out), .err_out(err_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int expLat(input int n);
`ifdef SHIFT_INV_FAST_EN
    return 1;
`else
    return n + 1;
`endif
  endfunction

  // Latency counts the accepting edge as clock 1; -1 means out_valid never came.
  task automatic sendReq(input logic [3:0] y, input logic [2:0] f, input logic [1:0] amt,
                         output int latency);
    int guard;
    @(negedge clk);
    y_in = y; f_in = f; amt_in = amt; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    y_in = ~y; f_in = ~f; amt_in = ~amt;
    latency = 1;
    while (!out_valid && latency < 20) begin
      @(posedge clk);
      #1;
      latency++;
    end
    if (!out_valid) latency = -1;
  endtask

  task automatic completeReq();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    y_in = '0; f_in = '0; amt_in = '0;
    #12;
    tests++;
    if ({in_ready, out_valid, a_out, exact_out, err_out} !== 8'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b want %b",
               {in_ready, out_valid, a_out, exact_out, err_out}, 8'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ready_before_edge: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_edge: got %b want 1", in_ready);
    end
  endtask

  task automatic test_rol();
    sendReq(4'b0111, 3'b100, 2'd1, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b1011_1_0) begin
      fails++;
      $display("[TB] FAIL rol_result: got %b want %b", {a_out, exact_out, err_out}, 6'b1011_1_0);
    end
    tests++;
    if (lat !== expLat(1)) begin
      fails++;
      $display("[TB] FAIL rol_latency: got %0d want %0d", lat, expLat(1));
    end
    completeReq();
  endtask

  task automatic test_lsl();
    sendReq(4'b1100, 3'b001, 2'd2, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b0011_0_0) begin
      fails++;
      $display("[TB] FAIL lsl_result: got %b want %b", {a_out, exact_out, err_out}, 6'b0011_0_0);
    end
    tests++;
    if (lat !== expLat(2)) begin
      fails++;
      $display("[TB] FAIL lsl_latency: got %0d want %0d", lat, expLat(2));
    end
    completeReq();
  endtask

  task automatic test_errors();
    sendReq(4'b1001, 3'b010, 2'd1, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b0010_0_1) begin
      fails++;
      $display("[TB] FAIL lsr_err: got %b want %b", {a_out, exact_out, err_out}, 6'b0010_0_1);
    end
    completeReq();
    sendReq(4'b0001, 3'b110, 2'd3, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b0000_0_1) begin
      fails++;
      $display("[TB] FAIL fix_lsl_err: got %b want %b", {a_out, exact_out, err_out}, 6'b0000_0_1);
    end
    tests++;
    if (lat !== expLat(1)) begin
      fails++;
      $display("[TB] FAIL fix_lsl_latency: got %0d want %0d", lat, expLat(1));
    end
    completeReq();
    sendReq(4'b0101, 3'b111, 2'd2, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b0000_0_1) begin
      fails++;
      $display("[TB] FAIL zero_err: got %b want %b", {a_out, exact_out, err_out}, 6'b0000_0_1);
    end
    completeReq();
    sendReq(4'b1010, 3'b000, 2'd2, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b1010_1_0) begin
      fails++;
      $display("[TB] FAIL pass_result: got %b want %b", {a_out, exact_out, err_out}, 6'b1010_1_0);
    end
    tests++;
    if (lat !== expLat(0)) begin
      fails++;
      $display("[TB] FAIL pass_latency: got %0d want %0d", lat, expLat(0));
    end
    completeReq();
  endtask

  task automatic test_asr();
    sendReq(4'b1101, 3'b011, 2'd1, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b1010_0_0) begin
      fails++;
      $display("[TB] FAIL asr_result: got %b want %b", {a_out, exact_out, err_out}, 6'b1010_0_0);
    end
    completeReq();
    sendReq(4'b1001, 3'b011, 2'd1, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b0010_0_1) begin
      fails++;
      $display("[TB] FAIL asr_err: got %b want %b", {a_out, exact_out, err_out}, 6'b0010_0_1);
    end
    completeReq();
  endtask

  task automatic test_backpressure();
    sendReq(4'b1000, 3'b001, 2'd3, lat);
    tests++;
    if (lat !== expLat(3)) begin
      fails++;
      $display("[TB] FAIL bp_latency: got %0d want %0d", lat, expLat(3));
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({out_valid, in_ready, a_out, exact_out, err_out} !== 8'b1_0_0001_0_0) begin
        fails++;
        $display("[TB] FAIL bp_hold%0d: got %b want %b", i,
                 {out_valid, in_ready, a_out, exact_out, err_out}, 8'b1_0_0001_0_0);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL bp_release: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_shift();
    bit sawValid;
    @(negedge clk);
    y_in = 4'b0011; f_in = 3'b101; amt_in = 2'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, a_out, exact_out, err_out} !== 8'b0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got %b want %b",
               {in_ready, out_valid, a_out, exact_out, err_out}, 8'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    tests++;
    if (sawValid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_no_valid: got %b want 0", sawValid);
    end
    sendReq(4'b0011, 3'b101, 2'd3, lat);
    tests++;
    if ({a_out, exact_out, err_out} !== 6'b1001_1_0) begin
      fails++;
      $display("[TB] FAIL after_reset_ror: got %b want %b", {a_out, exact_out, err_out}, 6'b1001_1_0);
    end
    tests++;
    if (lat !== expLat(3)) begin
      fails++;
      $display("[TB] FAIL after_reset_latency: got %0d want %0d", lat, expLat(3));
    end
    completeReq();
  endtask

  initial begin
    test_reset();
    test_rol();
    test_lsl();
    test_errors();
    test_asr();
    test_backpressure();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
